// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit_if : instruction-cache, redirect and decode-queue signal bundle  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface fetch_unit_if;
  logic [31:0] icache_address;
  logic [31:0] icache_instruction;
  logic        icache_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  // master: the fetch stage itself
  modport master (
    output icache_address,
    input  icache_instruction,
    input  icache_valid,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  // slave: cache, backend and decode seen from the other side
  modport slave (
    input  icache_address,
    output icache_instruction,
    output icache_valid,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit : PC owner, cache request FSM and {pc, instr} fetch queue        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int                 c_ptr_w    = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w    = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [31:0]        r_mem_pc    [FIFO_DEPTH];
  logic [31:0]        r_mem_instr [FIFO_DEPTH];

  logic w_flush;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_unused_redirect_lsb;

  assign w_flush = bus.redirect_valid;
  assign w_full  = (r_count == c_full_cnt);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.out_ready && !w_flush;
  assign w_unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // In REQ the cache still answers for the previous address, so valid is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    if (w_flush) begin
      w_state_nxt = ST_REQ;
      w_pc_nxt    = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      case (r_state)
        ST_REQ: w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (bus.icache_valid && !w_full) begin
            w_push      = 1'b1;
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = ST_REQ;
          end
        end
        default: w_state_nxt = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_push && !w_pop)
        r_count <= r_count + c_cnt_one;
      else if (!w_push && w_pop)
        r_count <= r_count - c_cnt_one;
    end
  end

  // Storage needs no reset: entries are only visible while the count covers them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_pc;
      r_mem_instr[r_wr_ptr] <= bus.icache_instruction;
    end
  end

  assign bus.icache_address = r_pc;
  assign bus.out_valid      = !w_empty;
  assign bus.out_pc         = w_empty ? 32'h0 : r_mem_pc[r_rd_ptr];
  assign bus.out_instr      = w_empty ? 32'h0 : r_mem_instr[r_rd_ptr];
endmodule
`default_nettype wire
